mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit that sits directly upstream of the 32-bit data RAM (byte/half/word modes, 1 K words, 12-bit byte address).
- Accepts one memory request at a time from the pipeline MEM stage over a valid/ready handshake.
- Checks alignment and range, drives the RAM port for exactly one cycle, then sign- or zero-extends load data.
- Returns a registered response with a fault flag.

Parameters:
- ADDR_W, 12: RAM byte-address width; the legal range is 0 to 2**ADDR_W-1.
- DATA_W, 32: data width; the only supported value is 32.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset (same net that clears the RAM).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bits used for byte/half.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  misaligned, out-of-range or illegal-size request.
- ram_addr  out  ADDR_W  to RAM Addr.
- ram_data_in  out  32  to RAM data_in.
- ram_mode  out  2  to RAM Mode (same encoding as req_size).
- ram_memWrite  out  1  to RAM write enable.
- ram_sel  out  1  to RAM sel.
- ram_data_out  in  32  from RAM; already right-aligned and zero-filled for byte/half.
- perf_loads, perf_stores, perf_faults  out  32 each  counters (see Optional Feature).

Behaviour:
- Reset (clr high, asynchronous):
  - state = IDLE.
  - req_ready = 1 once clr deasserts; rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0.
  - All ram_* outputs = 0; counters = 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1; all ram_* outputs held at 0.
  - On req_valid & req_ready at a clock edge, the request fields are captured into registers.
  - Fault check at capture. The request faults if any of these hold:
    - req_size == 11;
    - half with addr[0] = 1;
    - word with addr[1:0] != 00;
    - req_addr[31:ADDR_W] != 0.
  - No fault: next state is ACCESS. Fault: next state is RESP with rsp_fault = 1 and rsp_rdata = 0, and the RAM is never selected.
- ACCESS (exactly 1 cycle):
  - ram_sel = 1; ram_addr = captured addr[ADDR_W-1:0]; ram_mode = captured size.
  - ram_memWrite = captured we; ram_data_in = captured wdata.
  - A store commits in the RAM at the closing edge of this cycle.
  - For a load, ram_data_out is sampled at that edge and extended:
    - byte: bits 31:8 = bit 7 if signed, else 0;
    - half: bits 31:16 = bit 15 if signed, else 0;
    - word: passed unchanged.
  - The result goes to rsp_rdata. Next state: RESP.
- RESP:
  - rsp_valid = 1, holding rsp_rdata and rsp_fault stable until rsp_valid & rsp_ready at an edge; next state is IDLE.
  - req_ready = 0 in ACCESS and RESP, so there is no back-to-back overlap.
- Latency: acceptance at edge N, ACCESS during cycle N+1, rsp_valid from N+2.
  - Faulting requests skip ACCESS: rsp_valid from N+1.
  - Minimum issue interval: 3 cycles (2 for faults).
- Boundaries:
  - rsp_ready held high gives a 1-cycle RESP.
  - req_valid while busy is ignored; the requester must hold it.
  - Address 0xFFF with byte size is legal; 0x1000 faults.
- Reset mid-ACCESS: the transaction is dropped and no response is produced. A store may or may not commit; either outcome is acceptable because the RAM contents are cleared by the same clr.
- req_signed is ignored for stores and for word loads.

Optional Feature:
- Macro: MEM_ACCESS_PERF_CNT_EN.
- Defined:
  - perf_loads increments on each non-faulting load leaving ACCESS.
  - perf_stores increments on each non-faulting store leaving ACCESS.
  - perf_faults increments on each faulting acceptance.
  - All three wrap modulo 2**32 and reset on clr.
- Undefined: the ports still exist and are tied to 0, and no counter registers are instantiated.

Decomposition:
- Shared package mem_pkg holds:
  - size constants MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10 (shared with the RAM);
  - the LSU state typedef (IDLE/ACCESS/RESP).
- One natural sub-module: load_extender. It is combinational and takes size, signed and raw data in, and gives 32-bit extended data out. It is reused by the writeback stage.

Test Plan:
- Store word 0xDEADBEEF at 0x010, then lw at 0x010 -> rsp_rdata = 0xDEADBEEF, rsp_fault = 0, rsp_valid 2 cycles after acceptance.
- sb 0x80 at 0x013, then lb signed at 0x013 -> 0xFFFFFF80; lbu -> 0x00000080; lw at 0x010 -> 0x80ADBEEF.
- sh 0x8001 at 0x022, then lh -> 0xFFFF8001; lhu -> 0x00008001.
- lh at 0x021, lw at 0x002, size = 11, lw at 0x1000 -> each gives rsp_fault = 1, rsp_rdata = 0, ram_sel never high, and RAM contents unchanged.
- rsp_ready held low 5 cycles after a load -> rsp_valid and rsp_rdata stable for 5 cycles; req_ready = 0 throughout.
- clr pulsed during ACCESS of a store -> no rsp_valid, state IDLE, a subsequent lw at that address returns 0.
  - With MEM_ACCESS_PERF_CNT_EN defined, the counters also read 0 after the clr pulse.
  - After the earlier scenarios, the counters match the load/store/fault counts issued.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared access-size encodings, LSU state type and fault helper
//            used by the load/store unit, the RAM and the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Access-size encodings (identical on the RAM Mode input)
    localparam logic [1:0] MEM_BYTE    = 2'b00;
    localparam logic [1:0] MEM_HALF    = 2'b01;
    localparam logic [1:0] MEM_WORD    = 2'b10;
    localparam logic [1:0] MEM_ILLEGAL = 2'b11;

    // Load/store unit sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Illegal size or an address not naturally aligned to the access size
    function automatic logic size_align_fault(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic f;
        f = 1'b0;
        case (size)
            MEM_HALF:    f = addr_lo[0];
            MEM_WORD:    f = |addr_lo;
            MEM_ILLEGAL: f = 1'b1;
            default:     f = 1'b0;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module   : load_extender
// Purpose  : Combinational sign/zero extension of right-aligned load data.
//            Shared between the load/store unit and the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
module load_extender
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    // Replicate the top bit of the accessed lane when sign extension is asked for
    always_comb begin
        data = raw;
        case (size)
            MEM_BYTE: data = {{24{sign_ext & raw[7]}},  raw[7:0]};
            MEM_HALF: data = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default:  data = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-outstanding load/store unit in front of the data RAM.
//            Checks size/alignment/range, drives the RAM for one cycle and
//            returns an extended, registered response with a fault flag.
// Options  : MEM_ACCESS_PERF_CNT_EN - enables load/store/fault counters;
//            when undefined the perf ports read 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [1:0]        ram_mode,
    output logic              ram_memWrite,
    output logic              ram_sel,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_faults
);

    lsu_state_t        state;
    lsu_state_t        state_next;

    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_size;
    logic              cap_we;
    logic              cap_signed;
    logic [DATA_W-1:0] cap_wdata;

    logic              accept;
    logic              req_fault;
    logic [DATA_W-1:0] ext_data;

    assign accept    = req_valid & req_ready;
    // Any address bit above the RAM window makes the request out of range
    assign req_fault = size_align_fault(req_size, req_addr[1:0])
                     | (|req_addr[31:ADDR_W]);

    load_extender u_load_extender (
        .size     (cap_size),
        .sign_ext (cap_signed),
        .raw      (ram_data_out),
        .data     (ext_data)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: faults bypass the RAM cycle and go straight to the response
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_fault ? RESP : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: RAM port is only driven (non-zero) during the ACCESS cycle
    always_comb begin
        req_ready    = (state == IDLE);
        rsp_valid    = (state == RESP);
        ram_sel      = (state == ACCESS);
        ram_addr     = ram_sel ? cap_addr  : '0;
        ram_mode     = ram_sel ? cap_size  : 2'b00;
        ram_memWrite = ram_sel & cap_we;
        ram_data_in  = ram_sel ? cap_wdata : '0;
    end

    // Request capture and response data; a fault response carries zero data
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cap_addr   <= '0;
            cap_size   <= 2'b00;
            cap_we     <= 1'b0;
            cap_signed <= 1'b0;
            cap_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_fault  <= 1'b0;
        end else begin
            if (accept) begin
                cap_addr   <= req_addr[ADDR_W-1:0];
                cap_size   <= req_size;
                cap_we     <= req_we;
                cap_signed <= req_signed;
                cap_wdata  <= req_wdata;
                rsp_fault  <= req_fault;
                rsp_rdata  <= '0;
            end
            if (state == ACCESS) begin
                rsp_rdata <= cap_we ? '0 : ext_data;
            end
        end
    end

`ifdef MEM_ACCESS_PERF_CNT_EN
    logic [31:0] cnt_loads;
    logic [31:0] cnt_stores;
    logic [31:0] cnt_faults;

    // Event counters: completed accesses counted on leaving ACCESS, faults on acceptance
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_loads  <= '0;
            cnt_stores <= '0;
            cnt_faults <= '0;
        end else begin
            if (state == ACCESS) begin
                if (cap_we) cnt_stores <= cnt_stores + 32'd1;
                else        cnt_loads  <= cnt_loads  + 32'd1;
            end
            if (accept && req_fault) begin
                cnt_faults <= cnt_faults + 32'd1;
            end
        end
    end

    assign perf_loads  = cnt_loads;
    assign perf_stores = cnt_stores;
    assign perf_faults = cnt_faults;
`else
    assign perf_loads  = '0;
    assign perf_stores = '0;
    assign perf_faults = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with a byte-array RAM
//            model on the RAM port and an arithmetic reference model.
// Options  : MEM_ACCESS_PERF_CNT_EN - expected counter values follow it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [11:0] ram_addr;
    logic [31:0] ram_data_in;
    logic [1:0]  ram_mode;
    logic        ram_memWrite;
    logic        ram_sel;
    logic [31:0] ram_data_out;
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_faults;

    int total = 0;
    int bad   = 0;
    int n_ld  = 0;
    int n_st  = 0;
    int n_ft  = 0;

    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];

    mem_access_unit #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk          (clk),
        .clr          (clr),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_mode     (ram_mode),
        .ram_memWrite (ram_memWrite),
        .ram_sel      (ram_sel),
        .ram_data_out (ram_data_out),
        .perf_loads   (perf_loads),
        .perf_stores  (perf_stores),
        .perf_faults  (perf_faults)
    );

    always #5 clk = ~clk;

    // Little-endian byte RAM attached to the RAM port, cleared by clr
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        end else if (ram_sel && ram_memWrite) begin
            ram[ram_addr] <= ram_data_in[7:0];
            if (ram_mode != 2'b00) ram[ram_addr + 12'd1] <= ram_data_in[15:8];
            if (ram_mode == 2'b10) begin
                ram[ram_addr + 12'd2] <= ram_data_in[23:16];
                ram[ram_addr + 12'd3] <= ram_data_in[31:24];
            end
        end
    end

    always_comb begin
        ram_data_out = {24'h0, ram[ram_addr]};
        if (ram_mode == 2'b01)
            ram_data_out = {16'h0, ram[ram_addr + 12'd1], ram[ram_addr]};
        else if (ram_mode == 2'b10)
            ram_data_out = {ram[ram_addr + 12'd3], ram[ram_addr + 12'd2],
                            ram[ram_addr + 12'd1], ram[ram_addr]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: n = 2**size bytes, aligned and below 4 KiB, little-endian
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ft);
        int     n;
        longint v;
        n  = 1 << sz;
        ft = (sz == 2'd3) || ((a % 32'(n)) != 0) || (a > 32'hFFF);
        rd = 32'h0;
        if (ft) begin
            n_ft++;
        end else if (we) begin
            n_st++;
            for (int i = 0; i < n; i++) ref_mem[a[11:0] + 12'(i)] = 8'(wd >> (8 * i));
        end else begin
            n_ld++;
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[a[11:0] + 12'(i)]) << (8 * i));
            if (sg && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
            rd = v[31:0];
        end
    endtask

    // One full transaction; junk request held valid while busy must be ignored
    task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_rd, input logic exp_ft);
        int   lat;
        int   sels;
        logic stable;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_we = $urandom; req_size = 2'($urandom); req_signed = $urandom;
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; sels = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 10) begin
            if (ram_sel) sels++;
            lat++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check($sformatf("%s.latency", tag), 32'(lat), exp_ft ? 32'd0 : 32'd1);
        check($sformatf("%s.ram_sel_cycles", tag), 32'(sels), exp_ft ? 32'd0 : 32'd1);
        check($sformatf("%s.rdata", tag), rsp_rdata, exp_rd);
        check($sformatf("%s.fault", tag), {31'h0, rsp_fault}, {31'h0, exp_ft});
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== exp_rd || rsp_fault !== exp_ft || req_ready)
                stable = 1'b0;
        end
        if (hold > 0) check($sformatf("%s.hold_stable", tag), {31'h0, stable}, 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check($sformatf("%s.released", tag), {30'h0, rsp_valid, req_ready}, 32'h1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic [31:0] rd;
        logic        ft;
    } vec_t;

    vec_t tbl [22];

    task automatic check_counters(input string tag);
        logic [31:0] el, es, ef;
`ifdef MEM_ACCESS_PERF_CNT_EN
        el = 32'(n_ld); es = 32'(n_st); ef = 32'(n_ft);
`else
        el = 32'h0; es = 32'h0; ef = 32'h0;
`endif
        check($sformatf("%s.perf_loads", tag),  perf_loads,  el);
        check($sformatf("%s.perf_stores", tag), perf_stores, es);
        check($sformatf("%s.perf_faults", tag), perf_faults, ef);
    endtask

    initial begin
        logic [31:0] mrd;
        logic        mft;
        logic        quiet;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        //            we    sz     sg    addr          wdata          hold rdata          fault
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h010,      32'hDEADBEEF, 0, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h010,      32'h0,        0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h013,      32'hFFFFFF80, 0, 32'h00000000, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h013,      32'h0,        0, 32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h013,      32'h0,        0, 32'h00000080, 1'b0};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h010,      32'h0,        5, 32'h80ADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 2'd1, 1'b1, 32'h022,      32'h12348001, 0, 32'h00000000, 1'b0};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h022,      32'h0,        0, 32'hFFFF8001, 1'b0};
        tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h022,      32'h0,        0, 32'h00008001, 1'b0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h021,      32'h0,        0, 32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h002,      32'h0,        0, 32'h00000000, 1'b1};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h000,      32'h0,        0, 32'h00000000, 1'b1};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h1000,     32'h0,        0, 32'h00000000, 1'b1};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h011,      32'h11111111, 3, 32'h00000000, 1'b1};
        tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h1000,     32'h000000A5, 0, 32'h00000000, 1'b1};
        tbl[15] = '{1'b1, 2'd2, 1'b0, 32'h80000020, 32'h55555555, 0, 32'h00000000, 1'b1};
        tbl[16] = '{1'b0, 2'd2, 1'b1, 32'h010,      32'h0,        0, 32'h80ADBEEF, 1'b0};
        tbl[17] = '{1'b1, 2'd0, 1'b0, 32'h0FFF,     32'h0000005A, 0, 32'h00000000, 1'b0};
        tbl[18] = '{1'b0, 2'd0, 1'b1, 32'h0FFF,     32'h0,        0, 32'h0000005A, 1'b0};
        tbl[19] = '{1'b0, 2'd2, 1'b0, 32'h020,      32'h0,        0, 32'h80010000, 1'b0};
        tbl[20] = '{1'b0, 2'd2, 1'b0, 32'h000,      32'h0,        0, 32'h00000000, 1'b0};
        tbl[21] = '{1'b0, 2'd0, 1'b0, 32'h1000,     32'h0,        0, 32'h00000000, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("reset.req_ready", {31'h0, req_ready}, 32'h1);
        check("reset.rsp", {rsp_valid, rsp_fault, 30'h0} | rsp_rdata, 32'h0);
        check("reset.ram", {ram_sel, ram_memWrite, ram_mode, ram_addr} | ram_data_in, 32'h0);
        check("reset.perf", perf_loads | perf_stores | perf_faults, 32'h0);

        // Directed table
        for (int i = 0; i < 22; i++) begin
            model(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, mrd, mft);
            run($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr,
                tbl[i].wd, tbl[i].hold, tbl[i].rd, tbl[i].ft);
        end
        check_counters("after_table");

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            logic        we, sg;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            int          r;
            we = 1'($urandom);
            sg = 1'($urandom);
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            wd = $urandom;
            r  = $urandom % 16;
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'($urandom % 4096);
            else begin
                a = 32'($urandom_range(0, 63));
                if (r > 3 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            end
            model(we, sz, sg, a, wd, mrd, mft);
            run($sformatf("rnd%0d", i), we, sz, sg, a, wd, int'($urandom % 3), mrd, mft);
        end
        check_counters("after_random");

        // Reset during the ACCESS cycle of a store drops it and clears everything
        model(1'b1, 2'd2, 1'b0, 32'h040, 32'h12345678, mrd, mft);
        run("pre_clr_sw", 1'b1, 2'd2, 1'b0, 32'h040, 32'h12345678, 0, mrd, mft);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h040; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("clr.in_access", {31'h0, ram_sel}, 32'h1);
        clr = 1'b1;
        #1 clr = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        n_ld = 0; n_st = 0; n_ft = 0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || !req_ready || ram_sel) quiet = 1'b0;
        end
        check("clr.no_response_idle", {31'h0, quiet}, 32'h1);
        check_counters("after_clr");
        model(1'b0, 2'd2, 1'b0, 32'h040, 32'h0, mrd, mft);
        run("post_clr_lw", 1'b0, 2'd2, 1'b0, 32'h040, 32'h0, 0, 32'h00000000, 1'b0);
        model(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, mrd, mft);
        run("post_clr_lw10", 1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0, 32'h00000000, 1'b0);
        check_counters("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
